// File: rtl/seg7_capture_pkg.sv
// Shared constants for the 7-segment loopback checker: active-low digit
// patterns, sign patterns and FSM encoding.
package seg_pkg;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] DIG_0 = 7'b0000001;
    localparam logic [6:0] DIG_1 = 7'b1001111;
    localparam logic [6:0] DIG_2 = 7'b0010010;
    localparam logic [6:0] DIG_3 = 7'b0000110;
    localparam logic [6:0] DIG_4 = 7'b1001100;
    localparam logic [6:0] DIG_5 = 7'b0100100;
    localparam logic [6:0] DIG_6 = 7'b0100000;
    localparam logic [6:0] DIG_7 = 7'b0001111;
    localparam logic [6:0] DIG_8 = 7'b0000000;

    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [0:0] SETTLE = 1'b0;
    localparam logic [0:0] HOLD   = 1'b1;

    typedef struct packed {
        logic       err;
        logic [3:0] data;
    } seg_result_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Result handshake of the display decoder: one-entry valid/ready with an
// error qualifier on the data.
interface seg7_capture_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_err;

    modport master (
        output out_valid,
        output out_data,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low magnitude digit plus sign digit
// into a 4-bit two's-complement value with an error flag.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] digit,
    input  logic [6:0] sign,
    output logic       err,
    output logic [3:0] data
);

    logic [3:0] mag;
    logic       mag_ok;
    logic       neg;
    logic       sign_ok;

    always_comb begin
        mag    = '0;
        mag_ok = 1'b1;
        unique case (digit)
            DIG_0:   mag = 4'd0;
            DIG_1:   mag = 4'd1;
            DIG_2:   mag = 4'd2;
            DIG_3:   mag = 4'd3;
            DIG_4:   mag = 4'd4;
            DIG_5:   mag = 4'd5;
            DIG_6:   mag = 4'd6;
            DIG_7:   mag = 4'd7;
            DIG_8:   mag = 4'd8;
            default: mag_ok = 1'b0;
        endcase
    end

    assign neg     = (sign == SEG_MINUS);
    assign sign_ok = neg || (sign == SEG_BLANK);

    always_comb begin
        err  = 1'b0;
        data = '0;
        if (!mag_ok || !sign_ok) begin
            err = 1'b1;
        end else if (neg) begin
            // -0 has no display form; -8 wraps naturally to 4'b1000
            if (mag == 4'd0) err = 1'b1;
            else             data = (~mag) + 4'd1;
        end else begin
            if (mag == 4'd8) err = 1'b1;
            else             data = mag;
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples the two display digits, waits for STABLE_CYCLES identical samples,
// decodes once per stable value and offers it through a one-entry buffer.
module seg7_capture
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_num,
    input  logic [6:0]            seg_sin,
    seg7_capture_if.master        res,
    output logic                  ovf
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_param
        $error("seg7_capture: STABLE_CYCLES out of range 2..255");
    end

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]  num_q;
    logic [6:0]  sin_q;
    logic [0:0]  state;
    logic [7:0]  cnt;
    logic        changed;
    logic        capture;
    seg_result_t dec;
    logic        valid_q;
    logic [3:0]  data_q;
    logic        err_q;

    assign changed = ({seg_num, seg_sin} != {num_q, sin_q});
    assign capture = (state == SETTLE) && !changed && (cnt == CNT_LAST);

    seg7_decode u_decode (
        .digit (num_q),
        .sign  (sin_q),
        .err   (dec.err),
        .data  (dec.data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= SEG_BLANK;
            sin_q <= SEG_BLANK;
        end else begin
            num_q <= seg_num;
            sin_q <= seg_sin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            cnt   <= '0;
        end else begin
            case (state)
                SETTLE: begin
                    if (changed)      cnt   <= '0;
                    else if (capture) state <= HOLD;
                    else              cnt   <= cnt + 8'd1;
                end
                default: begin
                    if (changed) begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
            endcase
        end
    end

    // A capture coinciding with a handshake replaces the entry without overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ovf     <= 1'b0;
        end else if (capture) begin
            if (!valid_q || res.out_ready) begin
                valid_q <= 1'b1;
                data_q  <= dec.data;
                err_q   <= dec.err;
            end else begin
                ovf <= 1'b1;
            end
        end else if (valid_q && res.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign res.out_valid = valid_q;
    assign res.out_data  = data_q;
    assign res.out_err   = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed checks of seg7_capture with STABLE_CYCLES = 4.
module tb_seg7_capture;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_num;
    logic [6:0] seg_sin;
    logic       ovf;
    int         checks;
    int         failures;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_num (seg_num),
        .seg_sin (seg_sin),
        .res     (bus.master),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                           input logic e, input logic o);
        chk({tag, "_valid"}, {7'd0, bus.out_valid}, {7'd0, v});
        chk({tag, "_data"},  {4'd0, bus.out_data},  {4'd0, d});
        chk({tag, "_err"},   {7'd0, bus.out_err},   {7'd0, e});
        chk({tag, "_ovf"},   {7'd0, ovf},           {7'd0, o});
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        seg_num       = 7'b1111111;
        seg_sin       = 7'b1111111;
        bus.out_ready = 1'b0;

        step(2);
        chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);

        // +6: valid on the 5th edge after release
        seg_num = 7'b0100000;
        seg_sin = 7'b1111111;
        step(1);
        rst_n = 1'b1;
        step(4);
        chk("lat_pre_valid", {7'd0, bus.out_valid}, 8'd0);
        step(1);
        chk_out("pos6", 1'b1, 4'd6, 1'b0, 1'b0);

        // handshake clears, stable value not reported again
        bus.out_ready = 1'b1;
        step(1);
        chk("hs_clear", {7'd0, bus.out_valid}, 8'd0);
        step(6);
        chk("once_only", {7'd0, bus.out_valid}, 8'd0);

        // -8
        seg_num = 7'b0000000;
        seg_sin = 7'b1111110;
        step(5);
        chk_out("neg8", 1'b1, 4'b1000, 1'b0, 1'b0);

        // -1
        seg_num = 7'b1001111;
        step(5);
        chk_out("neg1", 1'b1, 4'b1111, 1'b0, 1'b0);

        // +8 is an error
        seg_num = 7'b0000000;
        seg_sin = 7'b1111111;
        step(5);
        chk_out("pos8_err", 1'b1, 4'd0, 1'b1, 1'b0);

        // -0 is an error
        seg_num = 7'b0000001;
        seg_sin = 7'b1111110;
        step(5);
        chk_out("neg0_err", 1'b1, 4'd0, 1'b1, 1'b0);

        // invalid sign pattern
        seg_num = 7'b0000110;
        seg_sin = 7'b0111111;
        step(5);
        chk_out("badsign_err", 1'b1, 4'd0, 1'b1, 1'b0);

        // invalid digit pattern
        seg_num = 7'b1010101;
        seg_sin = 7'b1111111;
        step(5);
        chk_out("baddig_err", 1'b1, 4'd0, 1'b1, 1'b0);

        // stable 3, glitch 2 cycles to 2, back to 3
        seg_num = 7'b0000110;
        step(5);
        chk_out("pos3", 1'b1, 4'd3, 1'b0, 1'b0);
        step(1);
        chk("pos3_hs", {7'd0, bus.out_valid}, 8'd0);
        seg_num = 7'b0010010;
        step(2);
        chk("glitch_nocap", {7'd0, bus.out_valid}, 8'd0);
        seg_num = 7'b0000110;
        step(4);
        chk("reglitch_pre", {7'd0, bus.out_valid}, 8'd0);
        step(1);
        chk_out("reglitch_cap", 1'b1, 4'd3, 1'b0, 1'b0);

        // capture on the same edge as a handshake: replace, no overflow
        bus.out_ready = 1'b0;
        seg_num = 7'b0001111;
        step(4);
        chk_out("held3", 1'b1, 4'd3, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step(1);
        chk_out("replace7", 1'b1, 4'd7, 1'b0, 1'b0);

        // capture while pending and not ready: dropped, ovf set
        bus.out_ready = 1'b0;
        seg_num = 7'b0100100;
        step(4);
        chk("ovf_pre", {7'd0, ovf}, 8'd0);
        step(1);
        chk_out("ovf_drop", 1'b1, 4'd7, 1'b0, 1'b1);
        step(3);
        chk("ovf_sticky", {7'd0, ovf}, 8'd1);

        // asynchronous reset mid-SETTLE with a pending result
        seg_num = 7'b1001100;
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 4'd0, 1'b0, 1'b0);

        // blank inputs after reset decode as an error capture
        seg_num = 7'b1111111;
        seg_sin = 7'b1111111;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("blank_pre", {7'd0, bus.out_valid}, 8'd0);
        step(1);
        chk_out("blank_err", 1'b1, 4'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
